// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: two-entry skid-buffered pipeline register.
// Handshake outputs (in_ready, out_valid) come from registered state only.
// Optional performance counters xfer_cnt / stall_cnt are compiled in
// when PIPE_STAGE_PERF_EN is defined.
//
// state | meaning
// EMPTY | no entry held, in_ready=1, out_valid=0
// ONE   | main holds the head entry, skid unused
// FULL  | main holds the head entry, skid holds the next one, in_ready=0
module pipe_stage_reg #(
  parameter int DATA_W       = 32,
  parameter bit CLR_ON_FLUSH = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [31:0]       xfer_cnt,
  output logic [31:0]       stall_cnt
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              in_xfer;
  logic              out_xfer;

  assign in_ready  = (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign out_data  = main_q;
  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = out_valid & out_ready;

  // Next-state and payload steering; flush overrides every handshake event.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
      if (CLR_ON_FLUSH) begin
        main_d = '0;
        skid_d = '0;
      end
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (in_xfer) begin
            main_d  = in_data;
            state_d = ONE;
          end
        end
        ONE: begin
          if (in_xfer && out_xfer) begin
            main_d = in_data;
          end else if (in_xfer) begin
            skid_d  = in_data;
            state_d = FULL;
          end else if (out_xfer) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (out_xfer) begin
            main_d  = skid_q;
            state_d = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // State and payload registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  logic [31:0] xfer_cnt_q, xfer_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  assign xfer_cnt  = xfer_cnt_q;
  assign stall_cnt = stall_cnt_q;

  // Free-running wrap-around counters; flush deliberately leaves them alone.
  always_comb begin
    xfer_cnt_d  = xfer_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (out_xfer) xfer_cnt_d = xfer_cnt_q + 32'd1;
    if (out_valid && !out_ready) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  // Counter registers, cleared only by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      xfer_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      xfer_cnt_q  <= xfer_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: the reference model is an ordered
// queue of entries the stage currently owns (capacity two).
module tb_pipe_stage_reg;
  parameter int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              flush = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] in_data = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [DATA_W-1:0] out_data;
`ifdef PIPE_STAGE_PERF_EN
  logic [31:0]       xfer_cnt;
  logic [31:0]       stall_cnt;
  int unsigned       mdl_xfers = 0;
  int unsigned       mdl_stalls = 0;
`endif

  pipe_stage_reg #(.DATA_W(DATA_W), .CLR_ON_FLUSH(1'b1)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef PIPE_STAGE_PERF_EN
    ,
    .xfer_cnt  (xfer_cnt),
    .stall_cnt (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  logic [DATA_W-1:0] exp_q[$];
  bit                pushed_now = 1'b0;
  int                n_checks = 0;
  int                n_pass = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [DATA_W-1:0] rand_data();
    logic [DATA_W-1:0] r = '0;
    for (int i = 0; i < DATA_W; i += 32) r = (r << 32) | DATA_W'($urandom);
    return r;
  endfunction

  // Drive one cycle's inputs shortly after the rising edge; record accepted entries.
  task automatic drive(input bit iv, input logic [DATA_W-1:0] d, input bit ordy, input bit fl);
    @(posedge clk);
    #2;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    pushed_now = iv && in_ready && !fl && rst;
    if (pushed_now) exp_q.push_back(d);
  endtask

  // Monitor: mid-cycle compare of DUT outputs against the queue model.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        int held;
        held = exp_q.size() - (pushed_now ? 1 : 0);
        check("out_valid", 256'(out_valid), 256'(held > 0));
        check("in_ready", 256'(in_ready), 256'(held < 2));
        if (out_valid && held > 0) check("out_data", 256'(out_data), 256'(exp_q[0]));
        if (out_valid && out_ready && held > 0) void'(exp_q.pop_front());
`ifdef PIPE_STAGE_PERF_EN
        if (out_valid && out_ready) mdl_xfers++;
        if (out_valid && !out_ready) mdl_stalls++;
`endif
        if (flush) exp_q.delete();
      end
    end
  end

  initial begin
    #1;
    check("reset_out_valid", 256'(out_valid), 256'(0));
    check("reset_in_ready", 256'(in_ready), 256'(1));
    check("reset_out_data", 256'(out_data), 256'(0));
    @(posedge clk);
    #2 rst = 1'b1;

    // Streaming at full rate.
    drive(1, DATA_W'(8'h11), 1, 0);
    drive(1, DATA_W'(8'h22), 1, 0);
    drive(1, DATA_W'(8'h33), 1, 0);
    drive(0, '0, 1, 0);
    drive(0, '0, 1, 0);

    // Backpressure into FULL, then drain two.
    drive(1, DATA_W'(4'hA), 0, 0);
    drive(1, DATA_W'(4'hB), 0, 0);
    drive(0, '0, 0, 0);
    #3;
    check("bp_in_ready_full", 256'(in_ready), 256'(0));
    check("bp_head_held", 256'(out_data), 256'(DATA_W'(4'hA)));
    drive(0, '0, 1, 0);
    drive(0, '0, 1, 0);
    drive(0, '0, 1, 0);

    // Flush from FULL with a competing input.
    drive(1, DATA_W'(4'hC), 0, 0);
    drive(1, DATA_W'(4'hD), 0, 0);
    drive(1, DATA_W'(4'hE), 0, 1);
    drive(0, '0, 1, 0);
    #3;
    check("flush_out_valid", 256'(out_valid), 256'(0));
    check("flush_out_data", 256'(out_data), 256'(0));
    drive(0, '0, 1, 0);

    // Asynchronous reset between edges while FULL.
    drive(1, rand_data(), 0, 0);
    drive(1, rand_data(), 0, 0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    in_valid = 1'b0;
    pushed_now = 1'b0;
    exp_q.delete();
    #1;
    check("arst_out_valid", 256'(out_valid), 256'(0));
    check("arst_in_ready", 256'(in_ready), 256'(1));
    check("arst_out_data", 256'(out_data), 256'(0));
`ifdef PIPE_STAGE_PERF_EN
    check("arst_xfer_cnt", 256'(xfer_cnt), 256'(0));
    check("arst_stall_cnt", 256'(stall_cnt), 256'(0));
    mdl_xfers = 0;
    mdl_stalls = 0;
`endif
    @(posedge clk);
    #2 rst = 1'b1;
    drive(1, DATA_W'(8'h5A), 1, 0);
    drive(0, '0, 1, 0);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      drive(bit'($urandom_range(0, 1)), rand_data(), $urandom_range(0, 9) < 7,
            $urandom_range(0, 24) == 0);
    end
    for (int i = 0; i < 4; i++) drive(0, '0, 1, 0);
    @(negedge clk);
    #1;
    check("drain_empty", 256'(exp_q.size()), 256'(0));
`ifdef PIPE_STAGE_PERF_EN
    check("xfer_cnt", 256'(xfer_cnt), 256'(mdl_xfers));
    check("stall_cnt", 256'(stall_cnt), 256'(mdl_stalls));
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
